// File: rtl/acl2_seq_pkg.sv
// ============================================================================
// Module  : acl2_seq_pkg
// Brief   : State, command and delay-length definitions shared by the ACL2
//           mode sequencer and its timers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package acl2_seq_pkg;

    localparam int TIMER_W = 32;

    typedef enum logic [3:0] {
        ST_PWR_WAIT    = 4'd0,
        ST_RST_ISSUE   = 4'd1,
        ST_RST_ACK     = 4'd2,
        ST_RST_DONE    = 4'd3,
        ST_SETTLE      = 4'd4,
        ST_INIT_ISSUE  = 4'd5,
        ST_INIT_ACK    = 4'd6,
        ST_INIT_DONE   = 4'd7,
        ST_START_ISSUE = 4'd8,
        ST_START_ACK   = 4'd9,
        ST_START_DONE  = 4'd10,
        ST_RUNNING     = 4'd11
    } seq_state_t;

    // One bit per driver command; bit order matches the output port mapping.
    typedef logic [4:0] cmd_onehot_t;

    localparam cmd_onehot_t CMD_NONE         = 5'b00000;
    localparam cmd_onehot_t CMD_SOFT_RESET   = 5'b00001;
    localparam cmd_onehot_t CMD_INIT_LINKED  = 5'b00010;
    localparam cmd_onehot_t CMD_START_LINKED = 5'b00100;
    localparam cmd_onehot_t CMD_INIT_MEASUR  = 5'b01000;
    localparam cmd_onehot_t CMD_START_MEASUR = 5'b10000;

    function automatic logic [TIMER_W-1:0] settle_cycles(input int fast, input int fclk, input int ms);
        if (fast != 0)
            return TIMER_W'(100);
        return TIMER_W'(fclk / 1000 * ms);
    endfunction

    function automatic logic [TIMER_W-1:0] wdog_cycles(input int fast, input int fclk, input int ms);
        if (fast != 0)
            return TIMER_W'(1000);
        return TIMER_W'(fclk / 1000 * ms);
    endfunction

endpackage

`default_nettype wire

// File: rtl/acl2_seq_if.sv
// ============================================================================
// Module  : acl2_seq_if
// Brief   : Operator controls, driver handshake and status bundle of the ACL2
//           mode sequencer; master = sequencer side, slave = board/driver side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface acl2_seq_if;

    logic       i_sel_linked;
    logic       i_req_restart;
    logic       i_command_ready;
    logic       i_data_valid;
    logic       o_cmd_soft_reset_acl2;
    logic       o_cmd_init_linked_mode;
    logic       o_cmd_start_linked_mode;
    logic       o_cmd_init_measur_mode;
    logic       o_cmd_start_measur_mode;
    logic       o_running;
    logic       o_mode_linked;
    logic [3:0] o_seq_state;
    logic       o_wdog_fault;

    modport master (
        input  i_sel_linked, i_req_restart, i_command_ready, i_data_valid,
        output o_cmd_soft_reset_acl2, o_cmd_init_linked_mode, o_cmd_start_linked_mode,
               o_cmd_init_measur_mode, o_cmd_start_measur_mode,
               o_running, o_mode_linked, o_seq_state, o_wdog_fault
    );

    modport slave (
        output i_sel_linked, i_req_restart, i_command_ready, i_data_valid,
        input  o_cmd_soft_reset_acl2, o_cmd_init_linked_mode, o_cmd_start_linked_mode,
               o_cmd_init_measur_mode, o_cmd_start_measur_mode,
               o_running, o_mode_linked, o_seq_state, o_wdog_fault
    );

endinterface

`default_nettype wire

// File: rtl/acl2_seq_delay_timer.sv
// ============================================================================
// Module  : acl2_seq_delay_timer
// Brief   : Loadable down-counter that saturates at zero; done while zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acl2_seq_delay_timer #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_value,
    output logic                  done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= RESET_VALUE;
        else if (load)
            r_count <= load_value;
        else if (r_count != '0)
            r_count <= r_count - WIDTH'(1);
    end

    assign done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/acl2_mode_sequencer.sv
// ============================================================================
// Module  : acl2_mode_sequencer
// Brief   : Drives the ACL2 driver through settle, soft reset, init and start
//           in linked or measurement mode; re-runs on restart or mode change.
//           Optional running-data watchdog: define ACL2_SEQ_WATCHDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acl2_mode_sequencer
    import acl2_seq_pkg::*;
#(
    parameter int parm_fast_simulation = 0,
    parameter int FCLK                 = 20000000,
    parameter int parm_settle_ms       = 10,
    parameter int parm_ack_cycles      = 16,
    parameter int parm_wdog_ms         = 2000
) (
    input  wire logic  i_clk_20mhz,
    input  wire logic  i_rst_20mhz,
    acl2_seq_if.master bus
);

    localparam logic [TIMER_W-1:0] c_settle = settle_cycles(parm_fast_simulation, FCLK, parm_settle_ms);
    // The pulse cycle itself is the first acknowledge-window cycle.
    localparam logic [TIMER_W-1:0] c_ack    = TIMER_W'(parm_ack_cycles - 1);

    seq_state_t         r_state;
    seq_state_t         w_next;
    cmd_onehot_t        r_cmd;
    cmd_onehot_t        w_cmd_next;
    logic               r_running;
    logic               r_mode_linked;
    logic               r_restart_pending;
    logic               w_restart;
    logic               w_latch_mode;
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_value;
    logic               w_tmr_done;
    logic               w_wdog_expire;
    logic               w_ready;

    assign w_ready   = bus.i_command_ready;
    assign w_restart = r_restart_pending | bus.i_req_restart;

    acl2_seq_delay_timer #(
        .WIDTH       (TIMER_W),
        .RESET_VALUE (c_settle)
    ) u_seq_timer (
        .clk        (i_clk_20mhz),
        .rst        (i_rst_20mhz),
        .load       (w_tmr_load),
        .load_value (w_tmr_value),
        .done       (w_tmr_done)
    );

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz)
            r_state <= ST_PWR_WAIT;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_cmd_next   = CMD_NONE;
        w_tmr_load   = 1'b0;
        w_tmr_value  = c_settle;
        w_latch_mode = 1'b0;
        case (r_state)
            ST_PWR_WAIT: begin
                if (w_restart || w_tmr_done)
                    w_next = ST_RST_ISSUE;
            end
            ST_RST_ISSUE: begin
                if (w_ready) begin
                    w_cmd_next  = CMD_SOFT_RESET;
                    w_next      = ST_RST_ACK;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_ack;
                end
            end
            ST_RST_ACK: begin
                if (!w_ready)
                    w_next = ST_RST_DONE;
                else if (w_tmr_done)
                    w_next = ST_RST_ISSUE;
            end
            ST_RST_DONE: begin
                if (w_ready) begin
                    if (w_restart) begin
                        w_next = ST_RST_ISSUE;
                    end else begin
                        w_next      = ST_SETTLE;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = c_settle;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_restart) begin
                    w_next = ST_RST_ISSUE;
                end else if (w_tmr_done) begin
                    w_next       = ST_INIT_ISSUE;
                    w_latch_mode = 1'b1;
                end
            end
            ST_INIT_ISSUE: begin
                if (w_restart) begin
                    w_next = ST_RST_ISSUE;
                end else if (w_ready) begin
                    w_cmd_next  = r_mode_linked ? CMD_INIT_LINKED : CMD_INIT_MEASUR;
                    w_next      = ST_INIT_ACK;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_ack;
                end
            end
            ST_INIT_ACK: begin
                if (!w_ready)
                    w_next = ST_INIT_DONE;
                else if (w_tmr_done)
                    w_next = ST_INIT_ISSUE;
            end
            ST_INIT_DONE: begin
                if (w_ready)
                    w_next = w_restart ? ST_RST_ISSUE : ST_START_ISSUE;
            end
            ST_START_ISSUE: begin
                if (w_restart) begin
                    w_next = ST_RST_ISSUE;
                end else if (w_ready) begin
                    w_cmd_next  = r_mode_linked ? CMD_START_LINKED : CMD_START_MEASUR;
                    w_next      = ST_START_ACK;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_ack;
                end
            end
            ST_START_ACK: begin
                if (!w_ready)
                    w_next = ST_START_DONE;
                else if (w_tmr_done)
                    w_next = ST_START_ISSUE;
            end
            ST_START_DONE: begin
                if (w_ready)
                    w_next = w_restart ? ST_RST_ISSUE : ST_RUNNING;
            end
            ST_RUNNING: begin
                if (bus.i_req_restart || (bus.i_sel_linked != r_mode_linked) || w_wdog_expire)
                    w_next = ST_RST_ISSUE;
            end
            default: w_next = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_cmd             <= CMD_NONE;
            r_running         <= 1'b0;
            r_mode_linked     <= 1'b0;
            r_restart_pending <= 1'b0;
        end else begin
            r_cmd     <= w_cmd_next;
            r_running <= (w_next == ST_RUNNING);
            if (w_latch_mode)
                r_mode_linked <= bus.i_sel_linked;
            // Reaching the soft-reset issue point satisfies any outstanding restart.
            if (r_state == ST_RST_ISSUE)
                r_restart_pending <= 1'b0;
            else if (bus.i_req_restart && (r_state != ST_RUNNING))
                r_restart_pending <= 1'b1;
        end
    end

`ifdef ACL2_SEQ_WATCHDOG_EN
    localparam logic [TIMER_W-1:0] c_wdog = wdog_cycles(parm_fast_simulation, FCLK, parm_wdog_ms);

    logic w_wdog_done;
    logic w_wdog_load;
    logic r_wdog_fault;

    assign w_wdog_load = (r_state != ST_RUNNING) || bus.i_data_valid;

    acl2_seq_delay_timer #(
        .WIDTH       (TIMER_W),
        .RESET_VALUE (c_wdog)
    ) u_wdog_timer (
        .clk        (i_clk_20mhz),
        .rst        (i_rst_20mhz),
        .load       (w_wdog_load),
        .load_value (c_wdog),
        .done       (w_wdog_done)
    );

    assign w_wdog_expire = (r_state == ST_RUNNING) && w_wdog_done && !bus.i_data_valid;

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz)
            r_wdog_fault <= 1'b0;
        else if (bus.i_req_restart)
            r_wdog_fault <= 1'b0;
        else if (w_wdog_expire)
            r_wdog_fault <= 1'b1;
    end

    assign bus.o_wdog_fault = r_wdog_fault;
`else
    logic w_unused_data_valid;

    assign w_unused_data_valid = bus.i_data_valid;
    assign w_wdog_expire       = 1'b0;
    assign bus.o_wdog_fault    = 1'b0;
`endif

    assign bus.o_cmd_soft_reset_acl2   = r_cmd[0];
    assign bus.o_cmd_init_linked_mode  = r_cmd[1];
    assign bus.o_cmd_start_linked_mode = r_cmd[2];
    assign bus.o_cmd_init_measur_mode  = r_cmd[3];
    assign bus.o_cmd_start_measur_mode = r_cmd[4];
    assign bus.o_running               = r_running;
    assign bus.o_mode_linked           = r_mode_linked;
    assign bus.o_seq_state             = r_state;

endmodule

`default_nettype wire
